// File: rtl/multi_debounce_reg.sv
// Multi-channel button input stage: synchroniser, tick-qualified stability filter,
// and rise/fall edge pulses plus press-and-hold auto-repeat for each channel.
module multi_debounce_reg #(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter int   REPEAT_DELAY  = 64,
    parameter int   REPEAT_PERIOD = 16,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rep
);

    localparam int CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
    localparam bit            REP_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   s;
        logic [CW-1:0]          cnt;
        logic                   q_r;
        logic                   rise_r;
        logic                   fall_r;
        logic                   rep_r;
        logic [RW-1:0]          rc;
        rep_state_t             state;
        logic                   upd;

        assign s   = sync_r[SYNC_STAGES-1];
        // Filtered level is about to take the synchronised value this clk.
        assign upd = (s != q_r) && tick && (cnt == CNT_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_r <= {SYNC_STAGES{RESET_LEVEL}};
            end else begin
                sync_r[0] <= din[i];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_r[k] <= sync_r[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q_r    <= RESET_LEVEL;
                cnt    <= '0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (s == q_r) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        q_r    <= s;
                        cnt    <= '0;
                        rise_r <= s;
                        fall_r <= ~s;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end

        // A release in DELAY/REPEAT returns to IDLE and suppresses any rep due that clk.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                rc    <= '0;
                rep_r <= 1'b0;
            end else begin
                rep_r <= 1'b0;
                case (state)
                    IDLE: begin
                        if (upd && s && REP_EN) begin
                            state <= DELAY;
                            rc    <= '0;
                        end
                    end
                    DELAY: begin
                        if (upd && !s) begin
                            state <= IDLE;
                            rc    <= '0;
                        end else if (tick) begin
                            if (rc == DLY_LAST) begin
                                rep_r <= 1'b1;
                                rc    <= '0;
                                state <= REPEAT;
                            end else begin
                                rc <= rc + RW'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (upd && !s) begin
                            state <= IDLE;
                            rc    <= '0;
                        end else if (tick) begin
                            if (rc == PER_LAST) begin
                                rep_r <= 1'b1;
                                rc    <= '0;
                            end else begin
                                rc <= rc + RW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rc    <= '0;
                    end
                endcase
            end
        end

        assign q[i]    = q_r;
        assign rise[i] = rise_r;
        assign fall[i] = fall_r;
        assign rep[i]  = rep_r;
    end

endmodule

// File: tb/tb_multi_debounce_reg.sv
// Directed bench for multi_debounce_reg: one instance at default parameters and one
// with a short filter (4) and fast auto-repeat (delay 8, period 3).
module tb_multi_debounce_reg;

    logic       clk = 1'b0;
    logic       rst_a, tick_a, rst_b, tick_b;
    logic [3:0] din_a, din_b;
    logic [3:0] q_a, rise_a, fall_a, rep_a;
    logic [3:0] q_b, rise_b, fall_b, rep_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multi_debounce_reg u_def (
        .clk  (clk),
        .rst  (rst_a),
        .tick (tick_a),
        .din  (din_a),
        .q    (q_a),
        .rise (rise_a),
        .fall (fall_a),
        .rep  (rep_a)
    );

    multi_debounce_reg #(
        .CHANNELS      (4),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (3),
        .RESET_LEVEL   (1'b0)
    ) u_fast (
        .clk  (clk),
        .rst  (rst_b),
        .tick (tick_b),
        .din  (din_b),
        .q    (q_b),
        .rise (rise_b),
        .fall (fall_b),
        .rep  (rep_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] eq, input logic [3:0] er,
                         input logic [3:0] ef, input logic [3:0] ep);
        chk({tag, "_q"},    q_b,    eq);
        chk({tag, "_rise"}, rise_b, er);
        chk({tag, "_fall"}, fall_b, ef);
        chk({tag, "_rep"},  rep_b,  ep);
    endtask

    initial begin
        rst_a = 1'b1; tick_a = 1'b1; din_a = 4'b1111;
        rst_b = 1'b1; tick_b = 1'b1; din_b = 4'b0000;

        // Reset held 3 clks with all buttons pressed, default parameters.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("a_rst_q", q_a, 4'b0000);
            chk("a_rst_pulses", rise_a | fall_a | rep_a, 4'b0000);
        end
        rst_a = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("a_hold_q", q_a, 4'b0000);
            chk("a_hold_pulses", rise_a | fall_a | rep_a, 4'b0000);
        end
        step();
        chk("a_edge18_q", q_a, 4'b1111);
        chk("a_edge18_rise", rise_a, 4'b1111);
        step();
        chk("a_edge19_q", q_a, 4'b1111);
        chk("a_edge19_rise", rise_a, 4'b0000);

        // Fast instance: leave reset, clean press and release on channel 0.
        step();
        chk_b("b_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_b = 1'b0;
        din_b = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_b("press_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        chk_b("press_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        step();
        chk_b("press_after", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        din_b = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_b("release_wait", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        chk_b("release_edge", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step();
        chk_b("release_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Bounce on channel 1: 1,0,1 at 3-clk intervals.
        din_b = 4'b0010;
        for (int k = 0; k < 3; k++) begin step(); chk_b("bounce_a", 4'b0000, 4'b0000, 4'b0000, 4'b0000); end
        din_b = 4'b0000;
        for (int k = 0; k < 3; k++) begin step(); chk_b("bounce_b", 4'b0000, 4'b0000, 4'b0000, 4'b0000); end
        din_b = 4'b0010;
        for (int k = 0; k < 5; k++) begin step(); chk_b("bounce_c", 4'b0000, 4'b0000, 4'b0000, 4'b0000); end
        step();
        chk_b("bounce_rise", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        step();
        chk_b("bounce_after", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        din_b = 4'b0000;
        for (int k = 0; k < 5; k++) begin step(); chk_b("bounce_rel", 4'b0010, 4'b0000, 4'b0000, 4'b0000); end
        step();
        chk_b("bounce_fall", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        step();
        chk_b("bounce_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Tick gating: one tick every 10 clks, channel 0.
        tick_b = 1'b0;
        din_b  = 4'b0001;
        step(); step();
        chk_b("gate_sync", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int t = 1; t <= 4; t++) begin
            tick_b = 1'b1;
            step();
            tick_b = 1'b0;
            if (t < 4) chk_b("gate_tick", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
            else       chk_b("gate_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
            for (int k = 0; k < 9; k++) begin
                step();
                chk_b("gate_between", (t < 4) ? 4'b0000 : 4'b0001, 4'b0000, 4'b0000, 4'b0000);
            end
        end
        tick_b = 1'b1;
        din_b  = 4'b0000;
        for (int k = 0; k < 5; k++) begin step(); chk_b("gate_rel", 4'b0001, 4'b0000, 4'b0000, 4'b0000); end
        step();
        chk_b("gate_fall", 4'b0000, 4'b0000, 4'b0001, 4'b0000);

        // Auto-repeat on channel 2; release lands on a repeat boundary.
        din_b = 4'b0100;
        for (int k = 0; k < 5; k++) begin step(); chk_b("rep_press", 4'b0000, 4'b0000, 4'b0000, 4'b0000); end
        step();
        chk_b("rep_rise", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        for (int k = 1; k <= 14; k++) begin
            step();
            chk_b("rep_hold", 4'b0100, 4'b0000, 4'b0000,
                  (k == 8 || k == 11 || k == 14) ? 4'b0100 : 4'b0000);
        end
        din_b = 4'b0000;
        for (int k = 15; k <= 19; k++) begin
            step();
            chk_b("rep_rel", 4'b0100, 4'b0000, 4'b0000, (k == 17) ? 4'b0100 : 4'b0000);
        end
        step();
        chk_b("rep_fall", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        for (int k = 0; k < 3; k++) begin step(); chk_b("rep_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000); end

        // Reset during DELAY on channel 3, then fresh debounce with din still high.
        din_b = 4'b1000;
        for (int k = 0; k < 5; k++) begin step(); chk_b("mid_press", 4'b0000, 4'b0000, 4'b0000, 4'b0000); end
        step();
        chk_b("mid_rise", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) begin step(); chk_b("mid_delay", 4'b1000, 4'b0000, 4'b0000, 4'b0000); end
        rst_b = 1'b1;
        step();
        chk_b("mid_rst1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step();
        chk_b("mid_rst2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin step(); chk_b("mid_again", 4'b0000, 4'b0000, 4'b0000, 4'b0000); end
        step();
        chk_b("mid_rise2", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_b("mid_hold", 4'b1000, 4'b0000, 4'b0000, (k == 8) ? 4'b1000 : 4'b0000);
        end
        din_b = 4'b0000;
        for (int k = 9; k <= 13; k++) begin
            step();
            chk_b("mid_rel", 4'b1000, 4'b0000, 4'b0000, (k == 11) ? 4'b1000 : 4'b0000);
        end
        step();
        chk_b("mid_fall", 4'b0000, 4'b0000, 4'b1000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
